// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR addresses, request types and read-modify-write helper
// for the counter/timer CSR file.
package csr_pkg;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MCOUNTEREN    = 12'h306;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    typedef enum logic [1:0] {
        CSR_NOP = 2'b00,
        CSR_RW  = 2'b01,
        CSR_RS  = 2'b10,
        CSR_RC  = 2'b11
    } csr_op_t;
    typedef enum logic [1:0] {
        PRIV_U = 2'd0,
        PRIV_S = 2'd1,
        PRIV_M = 2'd3
    } priv_mode_t;
    typedef struct packed {
        logic        valid;
        csr_op_t     op;
        logic [11:0] addr;
        logic [31:0] src;
        logic        src_is_zero;
    } csr_req_t;
    function automatic logic [31:0] csr_rmw(csr_op_t op, logic [31:0] old, logic [31:0] src);
        return op == CSR_RW ? src : op == CSR_RS ? (old | src) : op == CSR_RC ? (old & ~src) : old;
    endfunction
endpackage

// File: rtl/csr_counter.sv
// csr_counter: CNT_WIDTH event counter with inhibit and independent writes
// of the low and high 32-bit halves.
module csr_counter #(
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 inc_i,
    input  logic                 inhibit_i,
    input  logic                 wr_lo_i,
    input  logic                 wr_hi_i,
    input  logic [31:0]          wdata_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    // A half write freezes the other half for this cycle: no increment, no carry.
    always_comb begin
        cnt_d = wr_lo_i ? {cnt_q[CNT_WIDTH-1:32], wdata_i}
              : wr_hi_i ? {wdata_i[CNT_WIDTH-33:0], cnt_q[31:0]}
              : cnt_q + CNT_WIDTH'(inc_i && !inhibit_i);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign cnt_o = cnt_q;
endmodule

// File: rtl/csr_counter_file.sv
// csr_counter_file: Zicsr counter/timer CSRs with HPM counters, time prescaler,
// counter inhibit and privilege/enable checks; reads are same-cycle, writes commit next edge.
module csr_counter_file
    import csr_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 64,
    parameter int NUM_HPM   = 4,
    parameter int TIME_DIV  = 1
) (
    input  logic                                  clock_i,
    input  logic                                  reset_i,
    input  priv_mode_t                            priv_mode_i,
    input  logic                                  instr_retired_i,
    input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0] hpm_event_i,
    input  logic                                  csr_valid_i,
    input  logic [1:0]                            csr_op_i,
    input  logic [11:0]                           csr_addr_i,
    input  logic [XLEN-1:0]                       csr_src_i,
    input  logic                                  csr_src_is_zero_i,
    output logic [XLEN-1:0]                       read_value_o,
    output logic                                  illegal_instr_exception_o
);
    localparam int          NUM_CNT  = NUM_HPM + 3;
    localparam logic [31:0] EN_MASK  = 32'((64'd1 << NUM_CNT) - 64'd1);
    localparam logic [31:0] INH_MASK = EN_MASK & ~32'h2;
    csr_req_t req;
    logic [4:0] idx;
    logic [11:0] base;
    logic ucnt, mcnt, is_en, is_inh, exists, wr_req, priv_bad, cen_bad, illegal, we, tick;
    logic [63:0] full;
    logic [31:0] old, wdata;
    logic [31:0] mcounteren_q, mcounteren_d, mcountinhibit_q, mcountinhibit_d, presc_q, presc_d;
    logic [CNT_WIDTH-1:0] time_q, time_d;
    logic [CNT_WIDTH-1:0] cnt_w [32];
    assign req = '{valid: csr_valid_i, op: csr_op_t'(csr_op_i), addr: csr_addr_i,
                   src: csr_src_i[31:0], src_is_zero: csr_src_is_zero_i};
    // Counter index is the low five address bits in both the user and machine windows.
    always_comb begin
        idx = req.addr[4:0];
        base = {req.addr[11:5], 5'b0};
        ucnt = (base == CSR_CYCLE || base == CSR_CYCLEH) && 32'(idx) < 32'(NUM_CNT);
        mcnt = (base == CSR_MCYCLE || base == CSR_MCYCLEH) && 32'(idx) < 32'(NUM_CNT) && idx != 5'd1;
        is_en = req.addr == CSR_MCOUNTEREN;
        is_inh = req.addr == CSR_MCOUNTINHIBIT;
        exists = ucnt || mcnt || is_en || is_inh;
        full = is_en ? {32'b0, mcounteren_q} : is_inh ? {32'b0, mcountinhibit_q}
             : (ucnt || mcnt) ? 64'(cnt_w[idx]) : 64'b0;
        old = req.addr[7] ? full[63:32] : full[31:0];
        wdata = csr_rmw(req.op, old, req.src);
        wr_req = req.valid && (req.op == CSR_RW || (req.op != CSR_NOP && !req.src_is_zero));
        priv_bad = req.addr[9:8] > priv_mode_i;
        cen_bad = priv_mode_i != PRIV_M && ucnt && !mcounteren_q[idx];
        illegal = req.valid && req.op != CSR_NOP
                && (!exists || priv_bad || (wr_req && req.addr[11:10] == 2'b11) || cen_bad);
        we = wr_req && !illegal;
    end
    assign read_value_o = req.valid ? XLEN'(old) : '0;
    assign illegal_instr_exception_o = illegal;
    always_comb begin
        tick = presc_q == 32'(TIME_DIV - 1);
        presc_d = tick ? '0 : presc_q + 32'd1;
        time_d = time_q + CNT_WIDTH'(tick);
        mcounteren_d = (we && is_en) ? (wdata & EN_MASK) : mcounteren_q;
        mcountinhibit_d = (we && is_inh) ? (wdata & INH_MASK) : mcountinhibit_q;
    end
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            presc_q <= '0;
            time_q <= '0;
            mcounteren_q <= '0;
            mcountinhibit_q <= '0;
        end else begin
            presc_q <= presc_d;
            time_q <= time_d;
            mcounteren_q <= mcounteren_d;
            mcountinhibit_q <= mcountinhibit_d;
        end
    end
    for (genvar c = 0; c < 32; c++) begin : g_cnt
        if (c == 1) begin : g_time
            assign cnt_w[c] = time_q;
        end else if (c < NUM_CNT) begin : g_ctr
            logic inc;
            if (c == 0) begin : g_cyc
                assign inc = 1'b1;
            end else if (c == 2) begin : g_ret
                assign inc = instr_retired_i;
            end else begin : g_hpm
                assign inc = hpm_event_i[c-3];
            end
            csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_ctr (
                .clk_i    (clock_i),
                .rst_i    (reset_i),
                .inc_i    (inc),
                .inhibit_i(mcountinhibit_q[c]),
                .wr_lo_i  (we && mcnt && idx == 5'(c) && !req.addr[7]),
                .wr_hi_i  (we && mcnt && idx == 5'(c) && req.addr[7]),
                .wdata_i  (wdata),
                .cnt_o    (cnt_w[c])
            );
        end else begin : g_none
            assign cnt_w[c] = '0;
        end
    end
endmodule

// File: tb/tb_csr_counter_file.sv
// tb_csr_counter_file: directed stimulus with a behavioural counter-file model
// checked every cycle, plus hand-computed literal checks.
module tb_csr_counter_file;
    import csr_pkg::*;
    localparam int NUM_HPM = 4, TIME_DIV = 4, NCNT = NUM_HPM + 3;
    logic clk = 1'b0, rst = 1'b1, run = 1'b0;
    priv_mode_t priv;
    logic ir, valid, sz, ill;
    logic [NUM_HPM-1:0] hpm;
    logic [1:0] op;
    logic [11:0] addr;
    logic [31:0] src, rd;
    int n_chk = 0, n_fail = 0;
    logic [63:0] m_cnt [NCNT];
    logic [31:0] m_en, m_inh;
    int m_presc;

    csr_counter_file #(.XLEN(32), .CNT_WIDTH(64), .NUM_HPM(NUM_HPM), .TIME_DIV(TIME_DIV)) dut (
        .clock_i                  (clk),
        .reset_i                  (rst),
        .priv_mode_i              (priv),
        .instr_retired_i          (ir),
        .hpm_event_i              (hpm),
        .csr_valid_i              (valid),
        .csr_op_i                 (op),
        .csr_addr_i               (addr),
        .csr_src_i                (src),
        .csr_src_is_zero_i        (sz),
        .read_value_o             (rd),
        .illegal_instr_exception_o(ill)
    );

    always #5 clk = ~clk;

    // Model: what the current request must return and whether/what it writes.
    function automatic void m_eval(output logic [31:0] e_rd, output logic e_ill,
                                   output logic e_we, output logic [31:0] e_nv);
        int k, need;
        logic ucnt, mcnt, wreq;
        logic [63:0] v;
        logic [31:0] old;
        k = int'(addr[4:0]);
        ucnt = (addr >= 12'hC00 && addr < 12'hC00 + NCNT) || (addr >= 12'hC80 && addr < 12'hC80 + NCNT);
        mcnt = ((addr >= 12'hB00 && addr < 12'hB00 + NCNT) || (addr >= 12'hB80 && addr < 12'hB80 + NCNT)) && k != 1;
        v = (ucnt || mcnt) ? m_cnt[k] : addr == 12'h306 ? 64'(m_en) : addr == 12'h320 ? 64'(m_inh) : 64'd0;
        old = addr[7] ? v[63:32] : v[31:0];
        need = ucnt ? 0 : 3;
        wreq = valid && (op == 2'b01 || (op != 2'b00 && !sz));
        e_ill = valid && op != 2'b00 && (!(ucnt || mcnt || addr == 12'h306 || addr == 12'h320)
                || need > int'(priv) || (wreq && ucnt) || (priv != PRIV_M && ucnt && !m_en[k]));
        e_nv = op == 2'b01 ? src : op == 2'b10 ? (old | src) : (old & ~src);
        e_we = wreq && !e_ill;
        e_rd = valid ? old : 32'd0;
    endfunction

    always @(posedge clk) begin : model_upd
        logic [31:0] r, nv;
        logic i, w, hit;
        int k;
        m_eval(r, i, w, nv);
        k = int'(addr[4:0]);
        if (rst) begin
            for (int j = 0; j < NCNT; j++) m_cnt[j] = 64'd0;
            m_en = 0;
            m_inh = 0;
            m_presc = 0;
        end else begin
            for (int j = 0; j < NCNT; j++) begin
                if (j != 1) begin
                    hit = w && k == j && addr[11:8] == 4'hB;
                    if (hit && !addr[7]) m_cnt[j][31:0] = nv;
                    else if (hit) m_cnt[j][63:32] = nv;
                    else if (!m_inh[j])
                        m_cnt[j] = m_cnt[j] + ((j == 0) ? 64'd1 : (j == 2) ? 64'(ir) : 64'(hpm[j-3]));
                end
            end
            if (m_presc == TIME_DIV - 1) begin
                m_presc = 0;
                m_cnt[1] = m_cnt[1] + 64'd1;
            end else m_presc++;
            if (w && addr == 12'h306) m_en = nv & 32'((1 << NCNT) - 1);
            if (w && addr == 12'h320) m_inh = nv & 32'((1 << NCNT) - 1) & ~32'h2;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : cmp
        logic [31:0] c_rd, c_nv;
        logic c_ill, c_w;
        if (run) begin
            m_eval(c_rd, c_ill, c_w, c_nv);
            check("cycle read_value", rd, c_rd);
            check("cycle illegal", 32'(ill), 32'(c_ill));
        end
    end

    task automatic lit(input string name, input logic [31:0] e_rd, input logic e_ill, input bit chk_rd);
        logic [31:0] r, nv;
        logic i, w;
        #2;
        m_eval(r, i, w, nv);
        check({name, " illegal"}, 32'(ill), 32'(e_ill));
        check({name, " model illegal"}, 32'(i), 32'(e_ill));
        if (chk_rd) begin
            check({name, " read_value"}, rd, e_rd);
            check({name, " model read_value"}, r, e_rd);
        end
    endtask

    task automatic req(input priv_mode_t p, input logic v, input logic [1:0] o,
                       input logic [11:0] a, input logic [31:0] s, input logic z);
        priv = p; valid = v; op = o; addr = a; src = s; sz = z;
    endtask

    task automatic rd_req(input priv_mode_t p, input logic [11:0] a);
        req(p, 1'b1, 2'b10, a, 32'd0, 1'b1);
    endtask

    task automatic idle();
        req(PRIV_M, 1'b0, 2'b00, 12'h000, 32'd0, 1'b0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        ir = 1'b0; hpm = '0; idle();
        tick(2);
        run = 1'b1;
        rd_req(PRIV_M, 12'hC00); lit("reset mcycle", 32'd0, 1'b0, 1'b1);
        rst = 1'b0; idle(); tick(10);
        rd_req(PRIV_M, 12'hC00); lit("mcycle 10", 32'd10, 1'b0, 1'b1); tick(1);
        rd_req(PRIV_M, 12'hC80); lit("mcycleh 0", 32'd0, 1'b0, 1'b1); tick(1);
        rd_req(PRIV_M, 12'hC01); lit("time 3", 32'd3, 1'b0, 1'b1); tick(1);
        req(PRIV_M, 1'b1, 2'b01, 12'hB00, 32'hFFFF_FFFF, 1'b0); lit("mcycle rw old", 32'd13, 1'b0, 1'b1); tick(1);
        idle(); tick(1);
        rd_req(PRIV_M, 12'hC00); lit("carry lo", 32'd0, 1'b0, 1'b1); tick(1);
        rd_req(PRIV_M, 12'hC80); lit("carry hi", 32'd1, 1'b0, 1'b1); tick(1);
        req(PRIV_M, 1'b1, 2'b10, 12'h320, 32'h5, 1'b0); lit("inhibit rs", 32'd0, 1'b0, 1'b1); tick(1);
        idle(); ir = 1'b1; tick(5); ir = 1'b0;
        rd_req(PRIV_M, 12'hB02); lit("minstret frozen", 32'd0, 1'b0, 1'b1); tick(1);
        rd_req(PRIV_M, 12'hB00); lit("mcycle frozen", 32'd3, 1'b0, 1'b1); tick(1);
        req(PRIV_M, 1'b1, 2'b11, 12'h320, 32'h5, 1'b0); lit("inhibit rc", 32'd5, 1'b0, 1'b1); tick(1);
        idle(); ir = 1'b1; tick(1); ir = 1'b0;
        rd_req(PRIV_M, 12'hB02); lit("minstret resumed", 32'd1, 1'b0, 1'b1); tick(1);
        rd_req(PRIV_U, 12'hC02); lit("U instret disabled", 32'd0, 1'b1, 1'b0); tick(1);
        req(PRIV_M, 1'b1, 2'b01, 12'h306, 32'h4, 1'b0); lit("mcounteren rw", 32'd0, 1'b0, 1'b1); tick(1);
        rd_req(PRIV_U, 12'hC02); lit("U instret enabled", 32'd1, 1'b0, 1'b1); tick(1);
        rd_req(PRIV_U, 12'hB02); lit("U minstret", 32'd0, 1'b1, 1'b0); tick(1);
        rd_req(PRIV_U, 12'hC00); lit("U cycle disabled", 32'd0, 1'b1, 1'b0); tick(1);
        rd_req(PRIV_S, 12'hB00); lit("S mcycle", 32'd0, 1'b1, 1'b0); tick(1);
        req(PRIV_M, 1'b1, 2'b01, 12'hC00, 32'h123, 1'b0); lit("rw read-only", 32'd0, 1'b1, 1'b0); tick(1);
        req(PRIV_M, 1'b1, 2'b10, 12'hC00, 32'h0, 1'b1); lit("rs zero read-only", 32'd0, 1'b0, 1'b0); tick(1);
        req(PRIV_M, 1'b1, 2'b10, 12'hC00, 32'h10, 1'b0); lit("rs nonzero read-only", 32'd0, 1'b1, 1'b0); tick(1);
        idle(); hpm = 4'b0101; tick(3); hpm = '0;
        rd_req(PRIV_M, 12'hC03); lit("hpm3", 32'd3, 1'b0, 1'b1); tick(1);
        rd_req(PRIV_M, 12'hC04); lit("hpm4", 32'd0, 1'b0, 1'b1); tick(1);
        rd_req(PRIV_M, 12'hC05); lit("hpm5", 32'd3, 1'b0, 1'b1); tick(1);
        rd_req(PRIV_M, 12'hC07); lit("hpm7 absent", 32'd0, 1'b1, 1'b1); tick(1);
        rd_req(PRIV_M, 12'hB01); lit("B01 absent", 32'd0, 1'b1, 1'b1); tick(1);
        req(PRIV_M, 1'b1, 2'b01, 12'h320, 32'hFFFF_FFFF, 1'b0); tick(1);
        rd_req(PRIV_M, 12'h320); lit("inhibit mask", 32'h7D, 1'b0, 1'b1); tick(1);
        req(PRIV_M, 1'b1, 2'b01, 12'h306, 32'hFFFF_FFFF, 1'b0); tick(1);
        rd_req(PRIV_M, 12'h306); lit("counteren mask", 32'h7F, 1'b0, 1'b1); tick(1);
        req(PRIV_M, 1'b0, 2'b01, 12'hC00, 32'h0, 1'b0); lit("not valid", 32'd0, 1'b0, 1'b1); tick(1);
        req(PRIV_M, 1'b1, 2'b00, 12'h7FF, 32'h0, 1'b0); lit("nop op", 32'd0, 1'b0, 1'b1); tick(1);
        req(PRIV_M, 1'b1, 2'b01, 12'h320, 32'h0, 1'b0); tick(1);
        req(PRIV_M, 1'b1, 2'b01, 12'hB02, 32'h20, 1'b0); ir = 1'b1; tick(1); ir = 1'b0;
        rd_req(PRIV_M, 12'hB02); lit("minstret write wins", 32'h20, 1'b0, 1'b1); tick(1);
        req(PRIV_M, 1'b1, 2'b01, 12'hB82, 32'hABCD, 1'b0); tick(1);
        rd_req(PRIV_M, 12'hC82); lit("instreth", 32'hABCD, 1'b0, 1'b1); tick(1);
        rd_req(PRIV_M, 12'hC02); lit("instret lo kept", 32'h20, 1'b0, 1'b1); tick(1);
        req(PRIV_M, 1'b1, 2'b01, 12'hB00, 32'h55, 1'b0); rst = 1'b1; tick(1); rst = 1'b0;
        rd_req(PRIV_M, 12'hB82); lit("reset clears instreth", 32'd0, 1'b0, 1'b1); tick(1);
        rd_req(PRIV_M, 12'h306); lit("reset clears counteren", 32'd0, 1'b0, 1'b1); tick(1);
        idle(); tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/csr_counter_file.md
Name: csr_counter_file

Overview:
- Parametrised successor to the basic CSR unit: full Zicsr read-modify-write (RW/RS/RC) over counter/timer CSRs, configurable HPM counter count, time prescaler, counter inhibit and privilege/enable checking.
- Sits beside the execute stage. Decode supplies a CSR request; the block returns the old value combinationally and commits the write on the next clock edge.

Parameters:
- XLEN, 32, CSR data width.
- CNT_WIDTH, 64, counter width (33..64); upper bits beyond CNT_WIDTH read as 0.
- NUM_HPM, 4, number of mhpmcounter3.. implemented (0..29).
- TIME_DIV, 1, cycles per time tick (>=1).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- priv_mode  in  priv_mode_t  current privilege (U=0, S=1, M=3)
- instr_retired  in  1  one instruction retired this cycle
- hpm_event  in  NUM_HPM  per-HPM increment strobe
- csr_valid  in  1  CSR instruction present this cycle
- csr_op  in  2  01=RW, 10=RS, 11=RC (00 = no-op, never illegal)
- csr_addr  in  12  CSR address
- csr_src  in  XLEN  rs1 value or zero-extended uimm
- csr_src_is_zero  in  1  rs1=x0 / uimm=0 (suppresses RS/RC write)
- read_value  out  XLEN  old CSR value; 0 when !csr_valid
- illegal_instr_exception  out  1  request illegal; no state change

Behaviour:
- Address map:
  - cycle/time/instret C00/C01/C02, hpmcounterN C00+N; high halves C80+.
  - mcycle B00, minstret B02, mhpmcounterN B00+N; high halves B80+.
  - mcounteren 306, mcountinhibit 320.
- Reset: all counters 0, mcounteren 0, mcountinhibit 0, prescaler 0. Outputs are combinational and read 0 when csr_valid=0.
- Read path is combinational, same cycle: read_value = old value. Low half = bits [31:0]; high half = bits [CNT_WIDTH-1:32], zero-extended.
- New value:
  - RW: src.
  - RS: old | src.
  - RC: old & ~src.
- Write enable = csr_valid & legal & (op==RW | !csr_src_is_zero). Writes commit at the next posedge.
- Illegal conditions (any one raises illegal_instr_exception the same cycle, and no write occurs):
  - Address not implemented, including hpm index > NUM_HPM+2 and C01/B01 mismatch (B01 is not implemented).
  - csr_addr[9:8] > priv_mode.
  - Write enable would be asserted and csr_addr[11:10]==2'b11 (read-only space).
  - priv_mode != M, user counter read, and mcounteren[idx]==0.
- Counter update each cycle, with priority reset > CSR write of that half > increment:
  - mcycle += 1 unless mcountinhibit[0].
  - minstret += instr_retired unless mcountinhibit[2].
  - hpm[i] += hpm_event[i] unless mcountinhibit[i+3].
  - A write to one half replaces only that half; the other half does not take this cycle's increment.
  - Increments wrap modulo 2^CNT_WIDTH.
- time: prescaler counts 0..TIME_DIV-1. On reaching TIME_DIV-1 it returns to 0 and time += 1. time is not inhibitable and not writable (mtime lives elsewhere).
- mcountinhibit bit1 and mcounteren bits for unimplemented counters are hardwired 0; writes are ignored.
- CSR write to minstret in the same cycle as instr_retired: written value wins (no +1).
- Reset mid-operation clears everything regardless of csr_valid.

Decomposition:
- csr_pkg holds:
  - CSR address constants (CSR_CYCLE, CSR_CYCLEH, CSR_MCYCLE, CSR_MCOUNTEREN, CSR_MCOUNTINHIBIT, ...).
  - csr_op_t enum.
  - csr_req_t struct {valid, op, addr, src, src_is_zero}.
  - Helper function csr_rmw(op, old, src).
- Sub-module csr_counter: parametrised CNT_WIDTH counter with inc, inhibit, wr_lo, wr_hi, wdata. Instantiated for mcycle, minstret and NUM_HPM HPMs.

Test Plan:
- Reset, then 10 idle cycles, read C00 in M-mode -> read_value=10; C80 -> 0; no exception.
- Write B00 with 0xFFFFFFFF via RW, then idle 1 cycle -> C00=0x00000000 and C80=0x00000001 (carry into high half).
- mcountinhibit RS 0x5, then 5 instr_retired pulses -> minstret and mcycle frozen; RC 0x5 resumes counting.
- U-mode read C02 with mcounteren=0 -> illegal=1. After M writes mcounteren=0x4 -> U read legal; U read B02 -> illegal.
- RW to C00 in M -> illegal, no change. RS to C00 with csr_src_is_zero=1 -> legal read, no exception.
- TIME_DIV=4: 12 cycles after reset -> time=3. Same-cycle minstret write 0x20 with instr_retired=1 -> next-cycle minstret=0x20.
